// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between the fetch (IF) and data (DM) ports.
// Define ARB_FAIR_EN to let fetch win a collision that follows a data grant.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_f,
    output logic              stall_m
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              discard_q, discard_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic              if_ready_q, if_ready_d, dm_ready_q, dm_ready_d;
    logic              grant, grant_dm, done, last_dm;

`ifdef ARB_FAIR_EN
    logic last_dm_q, last_dm_d;
    assign last_dm = last_dm_q;
    always_comb last_dm_d = grant ? grant_dm : last_dm_q;
    always_ff @(posedge clk) last_dm_q <= !reset ? 1'b0 : last_dm_d;
`else
    assign last_dm = 1'b0;
`endif

    // gnt: 1 = DM. In RESP only the other port may be granted.
    always_comb begin
        done       = state_q == BUSY && cnt_q == 4'd0;
        grant      = state_q == IDLE ? (dm_req | if_req) :
                     state_q == RESP ? (gnt_q ? if_req : dm_req) : 1'b0;
        grant_dm   = state_q == IDLE ? dm_req & ~(if_req & last_dm) : ~gnt_q;
        state_d    = grant ? BUSY : state_q == RESP ? IDLE : done ? RESP : state_q;
        gnt_d      = grant ? grant_dm : gnt_q;
        cnt_d      = grant ? CNT_INIT : (state_q == BUSY && !done) ? cnt_q - 4'd1 : cnt_q;
        we_d       = grant ? grant_dm & dm_we : we_q;
        addr_d     = grant ? (grant_dm ? dm_addr : if_addr) : addr_q;
        wdata_d    = (grant && grant_dm) ? dm_wdata : wdata_q;
        discard_d  = (state_q == RESP ? 1'b0 : discard_q) |
                     (if_flush & ((state_q == BUSY & ~gnt_q) | (grant & ~grant_dm)));
        if_ready_d = done & ~gnt_q & ~discard_d;
        dm_ready_d = done & gnt_q;
        if_rdata_d = if_ready_d ? mem_rdata : if_rdata_q;
        dm_rdata_d = (dm_ready_d & ~we_q) ? mem_rdata : dm_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            cnt_q      <= 4'd0;
            discard_q  <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            cnt_q      <= cnt_d;
            discard_q  <= discard_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_ready_q <= if_ready_d;
            dm_ready_q <= dm_ready_d;
        end
    end

    // Stalls are masked during reset so every output reads 0 there.
    assign mem_en    = state_q == BUSY;
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign stall_f   = reset & if_req & ~if_ready_q;
    assign stall_m   = reset & dm_req & ~dm_ready_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench with a response scoreboard for mem_port_arbiter.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, if_req, if_flush, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic        if_ready, dm_ready, mem_en, mem_we, stall_f, stall_m;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;

    logic        if_req1, dm_req1;
    logic [31:0] if_addr1, dm_addr1, mem_rdata1;
    logic        if_ready1, dm_ready1, mem_en1, mem_we1, stall_f1, stall_m1;
    logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;

    int checks = 0, errors = 0;
    typedef struct {logic dm; logic [31:0] data;} exp_t;
    exp_t sb[$];
    logic [31:0] first;

    mem_port_arbiter #(.LAT(2)) dut (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_ready(if_ready), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_f(stall_f), .stall_m(stall_m));

    mem_port_arbiter #(.LAT(1)) dut1 (
        .clk(clk), .reset(reset), .if_req(if_req1), .if_addr(if_addr1), .if_flush(1'b0),
        .if_rdata(if_rdata1), .if_ready(if_ready1), .dm_req(dm_req1), .dm_we(1'b0),
        .dm_addr(dm_addr1), .dm_wdata(32'h0), .dm_rdata(dm_rdata1), .dm_ready(dm_ready1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(mem_rdata1), .stall_f(stall_f1), .stall_m(stall_m1));

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        return a == 32'h40 ? 32'hE3A01005 : (32'hC0DE0000 | a);
    endfunction

    // Memory macro: unwritten words read back a fixed pattern of their address.
    logic [31:0]  wmem [0:255];
    logic [255:0] wvalid = '0;
    assign mem_rdata  = wvalid[mem_addr[9:2]] ? wmem[mem_addr[9:2]] : exp_rd(mem_addr);
    assign mem_rdata1 = exp_rd(mem_addr1);
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            wmem[mem_addr[9:2]]   <= mem_wdata;
            wvalid[mem_addr[9:2]] <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic dm, input logic [31:0] d);
        sb.push_back('{dm: dm, data: d});
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && (if_ready === 1'b1 || dm_ready === 1'b1)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_unexpected: observed ready if=%b dm=%b expected none", if_ready, dm_ready);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_port", 32'(dm_ready), 32'(e.dm));
                chk("sb_data", dm_ready ? dm_rdata : if_rdata, e.data);
            end
        end
    end

    // Advance one cycle; a requester drops its req after the cycle its ready was seen.
    task automatic tick();
        logic ri, rd;
        ri = if_ready;
        rd = dm_ready;
        @(posedge clk);
        @(negedge clk);
        if (ri) if_req = 1'b0;
        if (rd) dm_req = 1'b0;
    endtask

    task automatic run_idle(input int max);
        int n;
        n = 0;
        while ((if_req || dm_req) && n < max) begin
            tick();
            n++;
        end
        chk("idle_bound", 32'(n < max), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; if_flush = 1'b0;
        if_addr = 32'h300; dm_addr = 32'h200; dm_wdata = 32'h0;
        if_req1 = 1'b0; dm_req1 = 1'b0; if_addr1 = 32'h0; dm_addr1 = 32'h0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_ctl", 32'({mem_en, mem_we, if_ready, dm_ready, stall_f, stall_m}), 32'd0);
            chk("rst_addr", mem_addr, 32'h0);
            chk("rst_wdata", mem_wdata, 32'h0);
            chk("rst_rdata", if_rdata | dm_rdata, 32'h0);
        end
        reset = 1'b1;
        push(1'b1, exp_rd(32'h200));
        push(1'b0, exp_rd(32'h300));
        #1;
        chk("rel_stall", 32'({stall_f, stall_m}), 32'd3);
        chk("rel_en0", 32'(mem_en), 32'd0);
        tick();
        chk("rel_en1", 32'(mem_en), 32'd1);
        chk("rel_addr", mem_addr, 32'h200);
        run_idle(20);

        if_req = 1'b1; if_addr = 32'h40;
        push(1'b0, 32'hE3A01005);
        #1;
        chk("sf_stall0", 32'(stall_f), 32'd1);
        tick();
        chk("sf_c1", 32'({mem_en, stall_f}), 32'd3);
        chk("sf_addr", mem_addr, 32'h40);
        tick();
        chk("sf_c2", 32'({mem_en, stall_f}), 32'd3);
        tick();
        chk("sf_c3", 32'({mem_en, if_ready, stall_f}), 32'd2);
        chk("sf_data", if_rdata, 32'hE3A01005);
        tick();
        chk("sf_c4", 32'({if_req, if_ready}), 32'd0);

        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEADBEEF;
        if_req = 1'b1; if_addr = 32'h44;
        push(1'b1, exp_rd(32'h200));
        push(1'b0, exp_rd(32'h44));
        tick();
        chk("col_we", 32'({mem_en, mem_we}), 32'd3);
        chk("col_addr", mem_addr, 32'h100);
        chk("col_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        tick();
        chk("col_dmrdy", 32'({dm_ready, if_ready}), 32'd2);
        tick();
        dm_we = 1'b0;
        chk("col_ifbusy", 32'({mem_en, mem_we}), 32'd2);
        chk("col_ifaddr", mem_addr, 32'h44);
        tick();
        tick();
        chk("col_ifrdy", 32'(if_ready), 32'd1);
        run_idle(20);
        dm_req = 1'b1; dm_addr = 32'h100;
        push(1'b1, 32'hDEADBEEF);
        run_idle(20);

        if_req = 1'b1; if_addr = 32'h48;
        tick();
        if_flush = 1'b1;
        tick();
        if_flush = 1'b0; if_addr = 32'h80;
        push(1'b0, exp_rd(32'h80));
        tick();
        chk("fl_nordy", 32'(if_ready), 32'd0);
        chk("fl_keep", if_rdata, exp_rd(32'h44));
        tick();
        chk("fl_idle", 32'(mem_en), 32'd0);
        run_idle(20);

        dm_req = 1'b1; dm_addr = 32'h20;
        push(1'b1, exp_rd(32'h20));
        run_idle(20);
        dm_req = 1'b1; dm_addr = 32'h24; if_req = 1'b1; if_addr = 32'h54;
`ifdef ARB_FAIR_EN
        first = 32'h54;
        push(1'b0, exp_rd(32'h54));
        push(1'b1, exp_rd(32'h24));
`else
        first = 32'h24;
        push(1'b1, exp_rd(32'h24));
        push(1'b0, exp_rd(32'h54));
`endif
        tick();
        chk("arb_first", mem_addr, first);
        run_idle(30);

        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h104; dm_wdata = 32'h12345678;
        tick();
        chk("rb_busy", 32'({mem_en, mem_we}), 32'd3);
        reset = 1'b0;
        tick();
        chk("rb_abort", 32'({mem_en, dm_ready, stall_m}), 32'd0);
        reset = 1'b1; dm_req = 1'b0; dm_we = 1'b0;
        tick();
        chk("rb_idle", 32'({mem_en, dm_ready}), 32'd0);
        if_req = 1'b1; if_addr = 32'h40;
        push(1'b0, 32'hE3A01005);
        tick();
        tick();
        tick();
        chk("rb_lat", 32'(if_ready), 32'd1);
        run_idle(20);

        dm_req1 = 1'b1; dm_addr1 = 32'h10; if_req1 = 1'b1; if_addr1 = 32'h60;
        tick();
        chk("l1_dm_busy", 32'(mem_en1), 32'd1);
        chk("l1_dm_addr", mem_addr1, 32'h10);
        tick();
        chk("l1_dm_rdy", 32'({dm_ready1, mem_en1}), 32'd2);
        chk("l1_dm_data", dm_rdata1, exp_rd(32'h10));
        dm_addr1 = 32'h14;
        tick();
        chk("l1_if_busy", 32'({mem_en1, dm_ready1}), 32'd2);
        chk("l1_if_addr", mem_addr1, 32'h60);
        tick();
        chk("l1_if_rdy", 32'(if_ready1), 32'd1);
        chk("l1_if_data", if_rdata1, exp_rd(32'h60));
        if_req1 = 1'b0;
        tick();
        chk("l1_dm2_addr", mem_addr1, 32'h14);
        chk("l1_dm2_busy", 32'({mem_en1, dm_ready1}), 32'd2);
        tick();
        chk("l1_dm2_rdy", 32'(dm_ready1), 32'd1);
        chk("l1_dm2_data", dm_rdata1, exp_rd(32'h14));
        dm_req1 = 1'b0;
        tick();
        chk("l1_idle", 32'({mem_en1, dm_ready1, if_ready1}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
